ut_param: RTL
=============

# ut_param

Parametrised processing unit: the next generation of the accumulator datapath. It combines an operand register R1, a WIDTH-bit ALU, a carry flag and an accumulator, and adds a zero flag, subtract and add-with-carry operations, and an optional multi-cycle unsigned shift-add multiplier with a busy handshake. It sits between data memory and the control unit. Memory words enter through `data_in`, and the accumulator drives `data_out`.

## Interface
- `WIDTH`, default 16: datapath width in bits (minimum 4).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; when 0, all state (R1, ACCU, carry, FSM, counter) holds.
- `sel_UAL`  in  3  operation select.
- `data_in`  in  WIDTH  memory word loaded into R1.
- `load_R1`  in  1  R1 <= `data_in`.
- `load_accu`  in  1  ACCU <= ALU result (or starts MUL).
- `load_carry`  in  1  carry <= ALU carry.
- `init_carry`  in  1  carry <= 0; has priority over `load_carry`.
- `data_out`  out  WIDTH  ACCU.
- `carry`  out  1  carry flag.
- `zero`  out  1  combinational `ACCU == 0`.
- `busy`  out  1  multiply in progress.

## Operation
**ALU**
- Combinational on registered R1 (B) and ACCU (A); arithmetic is WIDTH+1 bits wide.
- Operations by `sel_UAL`:
  - 000 NOR: ~(A|B).
  - 001 ADD: A+B.
  - 010 ADC: A+B+carry.
  - 011 SUB: A+~B+1; carry=1 means no borrow.
  - 100 AND.
  - 101 XOR.
  - 110 PASS: B.
  - 111 MUL: see Configuration.
- Carry output of the ALU:
  - Arithmetic ops: bit WIDTH of the sum.
  - Logic ops and PASS: 0.

**Load rules (`ce`=1, FSM IDLE)**
- R1, ACCU and carry update independently at the same edge.
- ACCU always uses the pre-edge R1. A `load_R1` at the same edge does not affect the ALU result.

**FSM**
- States are IDLE and MUL.
- IDLE→MUL: `load_accu` with `sel_UAL`=111 (macro defined).
- MUL→IDLE: after WIDTH iterations.
- In MUL, `load_R1`, `load_accu` and `load_carry` are ignored. `init_carry` is still honoured.

## Timing
- Reset values: R1=0, ACCU=0, carry=0, `busy`=0, FSM=IDLE, counter=0, so `zero`=1 at reset.
- Reset acts asynchronously at any time, including during MUL, and aborts the multiply. After reset release the unit is IDLE.
- Single-cycle operations: the result is visible on `data_out` and `carry` one cycle after the load edge.
- MUL:
  - Start edge T: multiplicand = ACCU and multiplier = R1 are captured into an internal 2·WIDTH product/shift register. The `load_carry` request is latched.
  - `busy`=1 from after T until edge T+WIDTH, i.e. WIDTH cycles.
  - Edge T+WIDTH: ACCU <= low WIDTH bits of the product. If the latched `load_carry` is set, carry <= OR of the high WIDTH bits (overflow). `busy` drops at the same edge.
  - A new command is accepted at the first edge with `busy`=0.
- `ce`=0 during MUL stretches the latency by one cycle per stalled cycle. `busy` stays high.
- `init_carry` together with `load_carry`: carry=0.
- `init_carry` during MUL clears carry immediately. The final MUL write then still applies if `load_carry` was latched.

## Configuration
- Macro: `UT_PARAM_MUL_EN`.
- Defined:
  - op 111 is the multi-cycle unsigned multiply described above.
  - FSM, counter and product register are present.
- Undefined:
  - op 111 = NOP: ACCU is rewritten with itself and the ALU carry is 0.
  - No FSM, and `busy` is tied to 0.
  - All operations are single-cycle.

## Test plan
All values use WIDTH=16.
- **Reset:** assert `rst`=0 mid-operation → `data_out`=0x0000, `carry`=0, `zero`=1, `busy`=0 immediately, with no clock needed.
- **ADD then ADC:** ACCU=0x0001, R1=0xFFFF, ADD with `load_carry` → ACCU=0x0000, carry=1, zero=1. Then R1=0x0002, ADC → ACCU=0x0003, carry=0.
- **SUB borrow:** ACCU=0x0005, R1=0x0007, SUB with `load_carry` → ACCU=0xFFFE, carry=0. With ACCU=0x0007, R1=0x0005 → ACCU=0x0002, carry=1.
- **MUL (macro on):** ACCU=0x0100, R1=0x0100, start with `load_carry` → `busy` high for exactly 16 cycles, then ACCU=0x0000, carry=1. With 0x00FF×0x0003 → ACCU=0x02FD, carry=0.
  - Toggling `load_R1` while busy leaves R1 unchanged.
- **Stall and abort:** `ce`=0 for 3 cycles mid-MUL → `busy` lasts 19 cycles and the result is unchanged. A `rst` pulse mid-MUL → IDLE with ACCU=0.
- **Priority and macro off:** `init_carry` and `load_carry` together on an ADD that overflows → carry=0. With the macro undefined, op 111 leaves ACCU unchanged and `busy` stays 0.

Source files
------------

// File: rtl/ut_param_if.sv
// Bus between the control unit (master) and the ut_param datapath (slave):
// operation/load controls and the memory word in, accumulator and flags out.
interface ut_param_if #(
   parameter int WIDTH = 16
) ();
   logic             ce;
   logic [2:0]       sel_UAL;
   logic [WIDTH-1:0] data_in;
   logic             load_R1;
   logic             load_accu;
   logic             load_carry;
   logic             init_carry;
   logic [WIDTH-1:0] data_out;
   logic             carry;
   logic             zero;
   logic             busy;

   // Handshake: a command is taken at a rising edge with ce=1 while busy=0;
   // while busy=1 the load strobes are ignored (init_carry still acts).
   modport master (
      output ce, sel_UAL, data_in, load_R1, load_accu, load_carry, init_carry,
      input  data_out, carry, zero, busy
   );

   modport slave (
      input  ce, sel_UAL, data_in, load_R1, load_accu, load_carry, init_carry,
      output data_out, carry, zero, busy
   );
endinterface

// File: rtl/ut_param.sv
// ut_param: parametrised accumulator datapath (R1, WIDTH-bit ALU, ACCU, carry/zero flags).
// Define UT_PARAM_MUL_EN to build op 111 as a multi-cycle shift-add multiplier with busy.
module ut_param #(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst,
   ut_param_if.slave bus,
   output logic      dbg_state
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_MUL  = 1'b1;

   localparam logic [2:0] OP_NOR  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_ADC  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_PASS = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   logic [WIDTH-1:0] r_r1;
   logic [WIDTH-1:0] r_accu;
   logic             r_carry;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_c;

   logic             w_idle;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_lo;
   logic             w_mul_ovf;
   logic             w_mul_lc;

   // A is ACCU, B is R1; arithmetic carries out of bit WIDTH, logic ops clear it.
   always_comb begin
      w_sum     = '0;
      w_alu_res = r_accu;
      w_alu_c   = 1'b0;
      case (bus.sel_UAL)
         OP_NOR:  w_alu_res = ~(r_accu | r_r1);
         OP_ADD: begin
            w_sum                = {1'b0, r_accu} + {1'b0, r_r1};
            {w_alu_c, w_alu_res} = w_sum;
         end
         OP_ADC: begin
            w_sum                = {1'b0, r_accu} + {1'b0, r_r1} + {{WIDTH{1'b0}}, r_carry};
            {w_alu_c, w_alu_res} = w_sum;
         end
         OP_SUB: begin
            w_sum                = {1'b0, r_accu} + {1'b0, ~r_r1} + {{WIDTH{1'b0}}, 1'b1};
            {w_alu_c, w_alu_res} = w_sum;
         end
         OP_AND:  w_alu_res = r_accu & r_r1;
         OP_XOR:  w_alu_res = r_accu ^ r_r1;
         OP_PASS: w_alu_res = r_r1;
         OP_MUL:  w_alu_res = r_accu;
         default: w_alu_res = r_accu;
      endcase
   end

`ifdef UT_PARAM_MUL_EN
   localparam int              CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [0:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_mcand;
   logic               r_mul_lc;
   logic [WIDTH:0]     w_partial;
   logic [2*WIDTH-1:0] w_prod_next;

   // Upper half accumulates the multiplicand when the current multiplier LSB is set,
   // then the whole register shifts right; after WIDTH steps it holds the product.
   always_comb begin
      w_partial   = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                  + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
      w_prod_next = {w_partial, r_prod[WIDTH-1:1]};
   end

   assign w_idle      = (r_state == S_IDLE);
   assign w_mul_start = bus.ce && w_idle && bus.load_accu && (bus.sel_UAL == OP_MUL);
   assign w_mul_done  = (r_state == S_MUL) && (r_cnt == LAST);
   assign w_mul_lo    = w_prod_next[WIDTH-1:0];
   assign w_mul_ovf   = |w_prod_next[2*WIDTH-1:WIDTH];
   assign w_mul_lc    = r_mul_lc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mul_lc <= 1'b0;
      end else if (bus.ce) begin
         if (w_mul_start) begin
            r_state  <= S_MUL;
            r_cnt    <= '0;
            r_prod   <= {{WIDTH{1'b0}}, r_r1};
            r_mcand  <= r_accu;
            r_mul_lc <= bus.load_carry;
         end else if (r_state == S_MUL) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_mul_done) begin
               r_state <= S_IDLE;
            end
         end
      end
   end

   assign bus.busy  = (r_state == S_MUL);
   assign dbg_state = r_state;
`else
   assign w_idle      = 1'b1;
   assign w_mul_start = 1'b0;
   assign w_mul_done  = 1'b0;
   assign w_mul_lo    = '0;
   assign w_mul_ovf   = 1'b0;
   assign w_mul_lc    = 1'b0;
   assign bus.busy    = 1'b0;
   assign dbg_state   = S_IDLE;
`endif

   // The ALU reads pre-edge R1, so a same-edge load_R1 never affects the ACCU result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_r1    <= '0;
         r_accu  <= '0;
         r_carry <= 1'b0;
      end else if (bus.ce) begin
         if (w_idle && bus.load_R1) begin
            r_r1 <= bus.data_in;
         end
         if (w_idle && bus.load_accu && !w_mul_start) begin
            r_accu <= w_alu_res;
         end else if (w_mul_done) begin
            r_accu <= w_mul_lo;
         end
         if (bus.init_carry) begin
            r_carry <= 1'b0;
         end else if (w_idle && bus.load_carry && !w_mul_start) begin
            r_carry <= w_alu_c;
         end else if (w_mul_done && w_mul_lc) begin
            r_carry <= w_mul_ovf;
         end
      end
   end

   assign bus.data_out = r_accu;
   assign bus.carry    = r_carry;
   assign bus.zero     = (r_accu == '0);
endmodule
